vga_timing_sequencer: RTL and testbench
=======================================

Name: vga_timing_sequencer

Overview:
- Controller for the VGA horizontal timing datapath (hsync generator plus its 10-bit pixel counter).
- Produces the PixelClock strobe that advances the horizontal counter and drives its four horizontal timing inputs.
- Holds a staged set of timing registers that are committed only at frame boundaries, so a mode change never produces a torn line or frame.
- Owns the vertical counter, vsync and the frame sequencing (start, graceful stop, commit) for the pong display.

Parameters:
- XRES, 10, width of horizontal timing values
- YRES, 10, width of vertical timing values and yposition
- DIVIDE, 4, system clocks per PixelClock period (even, >=2)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  run request; level
- cfg_valid  input  1  staging-register write strobe
- cfg_ready  output  1  staging write accepted when cfg_valid&cfg_ready
- cfg_sel  input  3  0=hSynch 1=hBack 2=hActive 3=hFront 4=vSynch 5=vBack 6=vActive 7=vFront
- cfg_data  input  max(XRES,YRES)  value; low XRES/YRES bits used
- cfg_commit  input  1  one-cycle pulse requesting staged->live copy
- commit_pending  output  1  commit requested, not yet applied
- LineEnd  input  1  level from hsync generator, high while xcount==EndCount
- PixelClock  output  1  pixel-rate square wave to hsync generator
- SynchPulse, BackPorch, ActiveVideo, FrontPorch  output  XRES each  live horizontal timing
- vsync  output  1  active-low vertical sync
- yposition  output  YRES  vertical line coordinate
- FrameEnd  output  1  one-cycle pulse at vertical wrap
- running  output  1  high in RUN or UPDATE

Behaviour:
- Reset values (live and staging): hSynch=96, hBack=48, hActive=640, hFront=16, vSynch=2, vBack=33, vActive=480, vFront=10.
- Reset state: STOP, div_cnt=0, ycount=0, PixelClock=0, vsync=1, FrameEnd=0, commit_pending=0, running=0, cfg_ready=1.
- Reset is honoured in any state and mid-frame; all staged writes are discarded.
- Divider: div_cnt counts 0..DIVIDE-1 in RUN only; PixelClock = (div_cnt < DIVIDE/2). The falling edge (the hsync advance point) occurs once per DIVIDE clocks.
- In STOP, div_cnt is held at 0 and PixelClock=0.
- Vertical: register LineEnd; a rising edge (LineEnd & ~LineEnd_q) increments ycount. LineEnd holding high over several clocks counts once.
- VEnd = vSynch+vBack+vActive+vFront (YRES-bit, modulo 2^YRES).
- When a rising edge occurs with ycount==VEnd: ycount<=0 and FrameEnd=1 for that one clock.
- vsync = ~(ycount >= vActive+vFront && ycount <= vActive+vFront+vSynch).
- yposition = ycount, combinational copy.
- Staging: cfg_ready=0 only in UPDATE. An accepted write updates the selected staging register next clock; writes are accepted in STOP and RUN, including while commit_pending=1.
- A cfg_commit pulse sets commit_pending.
- State machine:
  - STOP -> UPDATE when commit_pending.
  - STOP -> RUN when enable & ~commit_pending.
  - RUN -> UPDATE on the FrameEnd clock if commit_pending.
  - RUN -> STOP on the FrameEnd clock if ~enable and ~commit_pending (graceful stop: the frame completes, then ycount=0 and div_cnt=0).
  - UPDATE: one clock. Copy all 8 staging registers to live, clear commit_pending. Next state RUN if enable, else STOP. The divider keeps running in UPDATE when entered from RUN (no pixel lost).
- Simultaneous events:
  - cfg_valid and cfg_commit in the same clock: the write is included in the commit.
  - cfg_commit during UPDATE: sets commit_pending again, applied at the following frame end.
  - enable deasserted and reasserted within a frame: no stop.
- Width rules: sums are truncated to XRES/YRES bits with no saturation or overflow flag; zero-length intervals are legal.

Test Plan:
- Reset, enable=1, model hsync with EndCount=800 -> PixelClock period 4 clocks; ycount 0..525 then wrap; FrameEnd exactly once per 526 lines; vsync low for ycount 490..492.
- Hold LineEnd high 12 clocks -> ycount increments by exactly 1.
- In RUN, write vActive=200 then pulse cfg_commit at line 100 -> commit_pending=1 until FrameEnd; UPDATE 1 clock with cfg_ready=0; next frame wraps at line 245; live hActive unchanged until that point.
- Drop enable at line 300 -> frame completes to FrameEnd, then STOP, PixelClock=0, running=0, ycount=0; reassert -> RUN next clock.
- cfg_valid(sel=2, data=320) and cfg_commit in the same clock while STOP -> UPDATE next clock, ActiveVideo=320 one clock later, commit_pending=0.
- Assert reset mid-frame at line 400 after staged writes -> all outputs and staging return to reset values at the next clock.

Source files
------------

// File: rtl/vga_timing_sequencer.sv
// VGA timing sequencer: pixel-clock divider, vertical counter, vsync, and
// frame-boundary commit of staged horizontal/vertical timing registers.
module vga_timing_sequencer #(
    parameter int XRES   = 10,
    parameter int YRES   = 10,
    parameter int DIVIDE = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [2:0]                               cfg_sel,
    input  logic [((XRES > YRES) ? XRES : YRES)-1:0] cfg_data,
    input  logic                                     cfg_commit,
    output logic                                     commit_pending,
    input  logic                                     LineEnd,
    output logic                                     PixelClock,
    output logic [XRES-1:0]                          SynchPulse,
    output logic [XRES-1:0]                          BackPorch,
    output logic [XRES-1:0]                          ActiveVideo,
    output logic [XRES-1:0]                          FrontPorch,
    output logic                                     vsync,
    output logic [YRES-1:0]                          yposition,
    output logic                                     FrameEnd,
    output logic                                     running
);

    localparam int DW   = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam int HALF = DIVIDE / 2;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic            div_on_r, div_on_next_s;
    logic [DW-1:0]   div_cnt_r, div_cnt_next_s;
    logic            pixel_clock_r, pixel_clock_next_s;
    logic            line_end_q_r;
    logic [YRES-1:0] ycount_r, ycount_next_s;
    logic            frame_end_r, frame_end_next_s;
    logic            vsync_r, vsync_next_s;
    logic            commit_pending_r, commit_pending_next_s;
    logic            cfg_ready_r, running_r;
    logic            commit_req_s, cfg_acc_s, rise_s, wrap_s;
    logic [YRES-1:0] v_end_s, vs_lo_s, vs_hi_s;

    // index 0..3 = synch, back, active, front
    logic [XRES-1:0] h_stage_r [4];
    logic [XRES-1:0] h_live_r  [4];
    logic [YRES-1:0] v_stage_r [4];
    logic [YRES-1:0] v_live_r  [4];
    logic [XRES-1:0] h_stage_next_s [4];
    logic [XRES-1:0] h_live_next_s  [4];
    logic [YRES-1:0] v_stage_next_s [4];
    logic [YRES-1:0] v_live_next_s  [4];

    function automatic logic [XRES-1:0] h_reset_val(input int idx);
        case (idx)
            0:       h_reset_val = XRES'(96);
            1:       h_reset_val = XRES'(48);
            2:       h_reset_val = XRES'(640);
            default: h_reset_val = XRES'(16);
        endcase
    endfunction

    function automatic logic [YRES-1:0] v_reset_val(input int idx);
        case (idx)
            0:       v_reset_val = YRES'(2);
            1:       v_reset_val = YRES'(33);
            2:       v_reset_val = YRES'(480);
            default: v_reset_val = YRES'(10);
        endcase
    endfunction

    // Next-state logic; a commit pulse in the current clock counts as pending.
    always_comb begin
        commit_req_s = commit_pending_r | cfg_commit;
        state_next_s = state_r;
        case (state_r)
            ST_STOP: begin
                if (commit_req_s) begin
                    state_next_s = ST_UPDATE;
                end else if (enable) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (frame_end_r && commit_req_s) begin
                    state_next_s = ST_UPDATE;
                end else if (frame_end_r && !enable) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_UPDATE: begin
                if (enable) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: state_next_s = ST_STOP;
        endcase
    end

    // Datapath next values: staging, live copy, divider, vertical counter, vsync.
    always_comb begin
        cfg_acc_s = cfg_valid & (state_r != ST_UPDATE);
        for (int i = 0; i < 4; i++) begin
            h_stage_next_s[i] = (cfg_acc_s && cfg_sel == 3'(i)) ? cfg_data[XRES-1:0] : h_stage_r[i];
            v_stage_next_s[i] = (cfg_acc_s && cfg_sel == 3'(i + 4)) ? cfg_data[YRES-1:0] : v_stage_r[i];
            h_live_next_s[i]  = (state_r == ST_UPDATE) ? h_stage_r[i] : h_live_r[i];
            v_live_next_s[i]  = (state_r == ST_UPDATE) ? v_stage_r[i] : v_live_r[i];
        end
        commit_pending_next_s = (state_r == ST_UPDATE) ? cfg_commit : commit_req_s;

        // The divider keeps counting through an UPDATE entered from RUN.
        div_on_next_s = (state_next_s == ST_RUN) || (state_next_s == ST_UPDATE && div_on_r);
        if (div_on_next_s && div_on_r) begin
            div_cnt_next_s = (div_cnt_r == DW'(DIVIDE - 1)) ? DW'(0) : div_cnt_r + DW'(1);
        end else begin
            div_cnt_next_s = DW'(0);
        end
        pixel_clock_next_s = div_on_next_s && (div_cnt_next_s < DW'(HALF));

        v_end_s = v_live_r[0] + v_live_r[1] + v_live_r[2] + v_live_r[3];
        rise_s  = LineEnd & ~line_end_q_r;
        wrap_s  = div_on_r & rise_s & (ycount_r == v_end_s);
        if (state_next_s == ST_STOP) begin
            ycount_next_s = YRES'(0);
        end else if (div_on_r && rise_s) begin
            ycount_next_s = wrap_s ? YRES'(0) : ycount_r + YRES'(1);
        end else begin
            ycount_next_s = ycount_r;
        end
        frame_end_next_s = wrap_s;

        vs_lo_s      = v_live_next_s[2] + v_live_next_s[3];
        vs_hi_s      = vs_lo_s + v_live_next_s[0];
        vsync_next_s = ~((ycount_next_s >= vs_lo_s) && (ycount_next_s <= vs_hi_s));
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= ST_STOP;
            div_on_r         <= 1'b0;
            div_cnt_r        <= DW'(0);
            pixel_clock_r    <= 1'b0;
            line_end_q_r     <= 1'b0;
            ycount_r         <= YRES'(0);
            frame_end_r      <= 1'b0;
            vsync_r          <= 1'b1;
            commit_pending_r <= 1'b0;
            cfg_ready_r      <= 1'b1;
            running_r        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h_stage_r[i] <= h_reset_val(i);
                h_live_r[i]  <= h_reset_val(i);
                v_stage_r[i] <= v_reset_val(i);
                v_live_r[i]  <= v_reset_val(i);
            end
        end else begin
            state_r          <= state_next_s;
            div_on_r         <= div_on_next_s;
            div_cnt_r        <= div_cnt_next_s;
            pixel_clock_r    <= pixel_clock_next_s;
            line_end_q_r     <= LineEnd;
            ycount_r         <= ycount_next_s;
            frame_end_r      <= frame_end_next_s;
            vsync_r          <= vsync_next_s;
            commit_pending_r <= commit_pending_next_s;
            cfg_ready_r      <= (state_next_s != ST_UPDATE);
            running_r        <= (state_next_s != ST_STOP);
            for (int i = 0; i < 4; i++) begin
                h_stage_r[i] <= h_stage_next_s[i];
                h_live_r[i]  <= h_live_next_s[i];
                v_stage_r[i] <= v_stage_next_s[i];
                v_live_r[i]  <= v_live_next_s[i];
            end
        end
    end

    assign cfg_ready      = cfg_ready_r;
    assign commit_pending = commit_pending_r;
    assign PixelClock     = pixel_clock_r;
    assign SynchPulse     = h_live_r[0];
    assign BackPorch      = h_live_r[1];
    assign ActiveVideo    = h_live_r[2];
    assign FrontPorch     = h_live_r[3];
    assign vsync          = vsync_r;
    assign yposition      = ycount_r;
    assign FrameEnd       = frame_end_r;
    assign running        = running_r;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Directed bench for vga_timing_sequencer: LineEnd is driven as a short line
// so full frames stay cheap; expected values come from a small vertical model.
module tb_vga_timing_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_sel = 3'd0;
    logic [9:0] cfg_data = 10'd0;
    logic       cfg_commit = 1'b0;
    logic       commit_pending;
    logic       LineEnd = 1'b0;
    logic       PixelClock;
    logic [9:0] SynchPulse, BackPorch, ActiveVideo, FrontPorch;
    logic       vsync;
    logic [9:0] yposition;
    logic       FrameEnd;
    logic       running;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt   = 0;
    int exp_y    = 0;
    int m_vend   = 525;
    int m_lo     = 490;
    int m_hi     = 492;

    vga_timing_sequencer #(.XRES(10), .YRES(10), .DIVIDE(4)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .commit_pending(commit_pending),
        .LineEnd(LineEnd), .PixelClock(PixelClock),
        .SynchPulse(SynchPulse), .BackPorch(BackPorch),
        .ActiveVideo(ActiveVideo), .FrontPorch(FrontPorch),
        .vsync(vsync), .yposition(yposition), .FrameEnd(FrameEnd), .running(running)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (FrameEnd === 1'b1) fe_cnt++;
    endtask

    task automatic set_model(input int vs, input int vb, input int va, input int vf);
        m_vend = (vs + vb + va + vf) % 1024;
        m_lo   = (va + vf) % 1024;
        m_hi   = (va + vf + vs) % 1024;
    endtask

    // One line: LineEnd high for 'hi' clocks, then low for 3.
    task automatic do_line(input int hi);
        LineEnd = 1'b1;
        tick();
        exp_y = (exp_y == m_vend) ? 0 : exp_y + 1;
        check_value("yposition", 32'(yposition), 32'(exp_y));
        check_value("vsync", 32'(vsync), (exp_y >= m_lo && exp_y <= m_hi) ? 32'd0 : 32'd1);
        for (int i = 1; i < hi; i++) tick();
        LineEnd = 1'b0;
        repeat (3) tick();
    endtask

    task automatic run_lines(input int n);
        for (int k = 0; k < n; k++) do_line(4);
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [9:0] data);
        cfg_sel   = sel;
        cfg_data  = data;
        cfg_valid = 1'b1;
        check_value("cfg_ready_wr", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_running"}, 32'(running), 32'd0);
        check_value({tag, "_pixclk"}, 32'(PixelClock), 32'd0);
        check_value({tag, "_ypos"}, 32'(yposition), 32'd0);
        check_value({tag, "_vsync"}, 32'(vsync), 32'd1);
        check_value({tag, "_frameend"}, 32'(FrameEnd), 32'd0);
        check_value({tag, "_pending"}, 32'(commit_pending), 32'd0);
        check_value({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        check_value({tag, "_hsynch"}, 32'(SynchPulse), 32'd96);
        check_value({tag, "_hback"}, 32'(BackPorch), 32'd48);
        check_value({tag, "_hactive"}, 32'(ActiveVideo), 32'd640);
        check_value({tag, "_hfront"}, 32'(FrontPorch), 32'd16);
    endtask

    initial begin
        repeat (2) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        check_value("stop_pixclk", 32'(PixelClock), 32'd0);
        check_value("stop_running", 32'(running), 32'd0);

        // Start: divider period of 4 clocks, high for the first two
        enable = 1'b1;
        fe_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_value("pixclk_pattern", 32'(PixelClock), (k % 4 < 2) ? 32'd1 : 32'd0);
        end
        check_value("run_running", 32'(running), 32'd1);

        // Full default frame: 0..525 then wrap, one FrameEnd
        run_lines(526);
        check_value("frame1_fe_count", 32'(fe_cnt), 32'd1);

        // Long LineEnd counts once
        do_line(12);
        check_value("hold12_ypos", 32'(yposition), 32'd1);
        check_value("hold12_fe_count", 32'(fe_cnt), 32'd1);

        // Enable glitch mid-frame does not stop; drop at line 300 stops at frame end
        run_lines(149);
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        run_lines(150);
        check_value("glitch_running", 32'(running), 32'd1);
        enable = 1'b0;
        run_lines(225);
        check_value("pre_stop_ypos", 32'(yposition), 32'd525);
        check_value("pre_stop_running", 32'(running), 32'd1);
        LineEnd = 1'b1;
        tick();
        exp_y = 0;
        check_value("stop_wrap_ypos", 32'(yposition), 32'd0);
        check_value("stop_wrap_fe", 32'(FrameEnd), 32'd1);
        tick();
        check_value("stopped_running", 32'(running), 32'd0);
        check_value("stopped_pixclk", 32'(PixelClock), 32'd0);
        repeat (2) tick();
        LineEnd = 1'b0;
        repeat (3) tick();
        check_value("stopped_pixclk2", 32'(PixelClock), 32'd0);
        check_value("stop_fe_count", 32'(fe_cnt), 32'd2);
        LineEnd = 1'b1;
        repeat (4) tick();
        LineEnd = 1'b0;
        tick();
        check_value("stop_ignores_line", 32'(yposition), 32'd0);

        // Write and commit in the same clock while stopped
        cfg_sel    = 3'd2;
        cfg_data   = 10'd320;
        cfg_valid  = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        check_value("stop_upd_ready", 32'(cfg_ready), 32'd0);
        check_value("stop_upd_pending", 32'(commit_pending), 32'd1);
        check_value("stop_upd_hactive_old", 32'(ActiveVideo), 32'd640);
        tick();
        check_value("stop_upd_hactive_new", 32'(ActiveVideo), 32'd320);
        check_value("stop_upd_pending_clr", 32'(commit_pending), 32'd0);
        check_value("stop_upd_ready_back", 32'(cfg_ready), 32'd1);
        check_value("stop_upd_running", 32'(running), 32'd0);
        enable = 1'b1;
        tick();
        check_value("restart_running", 32'(running), 32'd1);

        // Commit in RUN: applied only at frame end
        run_lines(100);
        cfg_write(3'd6, 10'd200);
        cfg_write(3'd2, 10'd512);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check_value("run_pending_set", 32'(commit_pending), 32'd1);
        check_value("run_hactive_hold", 32'(ActiveVideo), 32'd320);
        run_lines(425);
        check_value("run_pending_held", 32'(commit_pending), 32'd1);
        check_value("run_hactive_hold2", 32'(ActiveVideo), 32'd320);
        LineEnd = 1'b1;
        tick();
        exp_y = 0;
        check_value("upd_wrap_ypos", 32'(yposition), 32'd0);
        check_value("upd_wrap_fe", 32'(FrameEnd), 32'd1);
        tick();
        check_value("upd_ready_low", 32'(cfg_ready), 32'd0);
        check_value("upd_running", 32'(running), 32'd1);
        check_value("upd_hactive_old", 32'(ActiveVideo), 32'd320);
        tick();
        check_value("upd_ready_back", 32'(cfg_ready), 32'd1);
        check_value("upd_pending_clr", 32'(commit_pending), 32'd0);
        check_value("upd_hactive_new", 32'(ActiveVideo), 32'd512);
        tick();
        LineEnd = 1'b0;
        repeat (3) tick();
        check_value("upd_fe_count", 32'(fe_cnt), 32'd3);

        // Short frame with vActive=200 wraps after line 245; restore 480 meanwhile
        set_model(2, 33, 200, 10);
        run_lines(100);
        cfg_write(3'd6, 10'd480);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        run_lines(145);
        check_value("short_last_line", 32'(yposition), 32'd245);
        check_value("short_fe_before", 32'(fe_cnt), 32'd3);
        run_lines(1);
        check_value("short_fe_after", 32'(fe_cnt), 32'd4);
        check_value("short_pending_clr", 32'(commit_pending), 32'd0);
        set_model(2, 33, 480, 10);

        // Reset mid-frame at line 400 with uncommitted staged writes
        run_lines(400);
        cfg_write(3'd0, 10'd50);
        cfg_write(3'd4, 10'd7);
        enable  = 1'b0;
        reset   = 1'b1;
        LineEnd = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset   = 1'b0;
        LineEnd = 1'b0;
        tick();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
        check_value("discard_hsynch", 32'(SynchPulse), 32'd96);
        check_value("discard_hactive", 32'(ActiveVideo), 32'd640);
        check_value("discard_pending", 32'(commit_pending), 32'd0);
        check_value("discard_running", 32'(running), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
